// File: rtl/logic16_pipe.sv
// Purpose: pipelined bitwise logic unit (NOT/AND/OR/XOR, their complements, PASS a) over WIDTH-bit operands.
// Latency: LATENCY cycles from presentation to out_valid; full throughput of 1 result/cycle with out_ready=1.
// Backpressure: global stall; in_ready = !out_valid | out_ready, and every stage freezes while that is 0.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     input handshake for in_a, in_b, in_op
//   out_valid/out_ready   output handshake for out
//   out_zr, out_ng        result==0 and result sign bit; present only when LOGIC16_PIPE_FLAGS_EN is defined
// Opcodes: 000 ~a, 001 a&b, 010 a|b, 011 a^b, 100 ~(a&b), 101 ~(a|b), 110 ~(a^b), 111 a.
module logic16_pipe #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef LOGIC16_PIPE_FLAGS_EN
    output logic             out_zr,
    output logic             out_ng,
`endif
    output logic [WIDTH-1:0] out
);

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("logic16_pipe: LATENCY must be in 1..4");
        end
    endgenerate

    logic             advance;
    logic [WIDTH-1:0] fn_dat;

    logic [LATENCY-1:0] vld_q;
    logic [WIDTH-1:0]   dat_q [LATENCY];

    // Bubbles are not collapsed: the whole pipe moves or the whole pipe holds.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        fn_dat = '0;
        case (in_op)
            3'b000:  fn_dat = ~in_a;
            3'b001:  fn_dat = in_a & in_b;
            3'b010:  fn_dat = in_a | in_b;
            3'b011:  fn_dat = in_a ^ in_b;
            3'b100:  fn_dat = ~(in_a & in_b);
            3'b101:  fn_dat = ~(in_a | in_b);
            3'b110:  fn_dat = ~(in_a ^ in_b);
            default: fn_dat = in_a;
        endcase
    end

`ifdef LOGIC16_PIPE_FLAGS_EN
    logic               fn_zr;
    logic               fn_ng;
    logic [LATENCY-1:0] zr_q;
    logic [LATENCY-1:0] ng_q;

    assign fn_zr = (fn_dat == '0);
    assign fn_ng = fn_dat[WIDTH-1];
`endif

    // Stage 0 captures the computed function; later stages are plain delay.
    genvar s;
    generate
        for (s = 0; s < LATENCY; s++) begin : g_stage
            if (s == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) begin
                        vld_q[0] <= 1'b0;
                        dat_q[0] <= '0;
`ifdef LOGIC16_PIPE_FLAGS_EN
                        zr_q[0]  <= 1'b0;
                        ng_q[0]  <= 1'b0;
`endif
                    end else if (advance) begin
                        vld_q[0] <= in_valid;
                        dat_q[0] <= fn_dat;
`ifdef LOGIC16_PIPE_FLAGS_EN
                        zr_q[0]  <= fn_zr;
                        ng_q[0]  <= fn_ng;
`endif
                    end
                end
            end else begin : g_delay
                always_ff @(posedge clk) begin
                    if (reset) begin
                        vld_q[s] <= 1'b0;
                        dat_q[s] <= '0;
`ifdef LOGIC16_PIPE_FLAGS_EN
                        zr_q[s]  <= 1'b0;
                        ng_q[s]  <= 1'b0;
`endif
                    end else if (advance) begin
                        vld_q[s] <= vld_q[s-1];
                        dat_q[s] <= dat_q[s-1];
`ifdef LOGIC16_PIPE_FLAGS_EN
                        zr_q[s]  <= zr_q[s-1];
                        ng_q[s]  <= ng_q[s-1];
`endif
                    end
                end
            end
        end
    endgenerate

    assign out_valid = vld_q[LATENCY-1];
    assign out       = dat_q[LATENCY-1];
`ifdef LOGIC16_PIPE_FLAGS_EN
    assign out_zr    = zr_q[LATENCY-1];
    assign out_ng    = ng_q[LATENCY-1];
`endif

endmodule

// File: tb/tb_logic16_pipe.sv
// Purpose: randomized and directed stimulus for logic16_pipe with an expected-result queue.
// Latency: n/a (bench).
// Backpressure: out_ready driven randomly in the stall phases.
module tb_logic16_pipe;

    localparam int W   = 16;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
`ifdef LOGIC16_PIPE_FLAGS_EN
    logic         out_zr;
    logic         out_ng;
`endif

    logic16_pipe #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef LOGIC16_PIPE_FLAGS_EN
        .out_zr    (out_zr),
        .out_ng    (out_ng),
`endif
        .out       (out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         zr;
        logic         ng;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    int     npop   = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_out   = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Reference: bitwise semantics written per opcode from the truth-table definition.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        exp_t e;
        logic [W-1:0] r;
        logic [W-1:0] ones;
        ones = '1;
        case (op)
            3'd0: r = ones ^ a;
            3'd1: r = a & b;
            3'd2: r = a | b;
            3'd3: r = a ^ b;
            3'd4: r = ones ^ (a & b);
            3'd5: r = ones ^ (a | b);
            3'd6: r = ones ^ (a ^ b);
            default: r = a;
        endcase
        e.d  = r;
        e.zr = (r == 0);
        e.ng = r[W-1];
        return e;
    endfunction

    // Monitor / scoreboard: samples on the falling edge what the next rising edge will do.
    always @(negedge clk) begin
        exp_t e;
        chk("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
        if (reset) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", {31'b0, out_valid}, 32'd1);
                chk("stall_data_held", {16'b0, out}, {16'b0, prev_out});
            end
            if (out_valid && out_ready) begin
                chk("out_expected", {31'b0, q.size() != 0}, 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    npop++;
                    chk("out_data", {16'b0, out}, {16'b0, e.d});
`ifdef LOGIC16_PIPE_FLAGS_EN
                    chk("out_zr", {31'b0, out_zr}, {31'b0, e.zr});
                    chk("out_ng", {31'b0, out_ng}, {31'b0, e.ng});
`endif
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(in_a, in_b, in_op));
            prev_stall = out_valid && !out_ready;
            prev_out   = out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        chk("drain_queue_empty", q.size(), 0);
    endtask

    logic [W-1:0] exp8 [8];
    logic [W-1:0] pat  [10];

    initial begin
        int k;
        int n;
        int p0;
        logic acc;
        exp8 = '{16'hF0F0, 16'h0303, 16'h3F3F, 16'h3C3C, 16'hFCFC, 16'hC0C0, 16'hC3C3, 16'h0F0F};
        pat  = '{16'h0000, 16'hFFFF, 16'h00FF, 16'hFF00, 16'h0F0F,
                 16'hF0F0, 16'h3333, 16'hCCCC, 16'h5555, 16'hAAAA};

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out", {16'b0, out}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

        // Single NOT: valid for exactly one cycle, LATENCY cycles after presentation.
        in_valid = 1'b1; in_a = 16'h00FF; in_op = 3'd0;
        for (int c = 0; c <= LAT; c++) begin
            tick();
            in_valid = 1'b0;
            chk("single_valid_timing", {31'b0, out_valid}, {31'b0, c == LAT - 1});
            if (c == LAT - 1)
                chk("single_not_data", {16'b0, out}, 32'h0000FF00);
        end

        // All eight opcodes back to back.
        for (int i = 0; i < 8 + LAT - 1; i++) begin
            if (i < 8) begin
                in_valid = 1'b1; in_a = 16'h0F0F; in_b = 16'h3333; in_op = 3'(i);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i - (LAT - 1) >= 0) begin
                chk("stream_valid", {31'b0, out_valid}, 32'd1);
                chk("stream_data", {16'b0, out}, {16'b0, exp8[i - (LAT - 1)]});
            end
        end
        in_valid = 1'b0;
        drain();

        // Ten NOT patterns under random backpressure.
        p0 = npop;
        k = 0; n = 0;
        while (k < 10 && n < 300) begin
            in_valid = 1'b1; in_a = pat[k]; in_op = 3'd0;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            n++;
        end
        chk("bp_all_issued", k, 10);
        drain();
        chk("bp_result_count", npop - p0, 10);

        // Reset with two results in flight and the output stalled.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'h1234; in_op = 3'd0;
        tick();
        in_a = 16'h5678;
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midreset_out", {16'b0, out}, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        p0 = npop;
        repeat (LAT + 3) tick();
        chk("midreset_no_stale", npop - p0, 0);

`ifdef LOGIC16_PIPE_FLAGS_EN
        in_valid = 1'b1; in_a = 16'hFFFF; in_op = 3'd0;
        tick();
        in_a = 16'h0001;
        tick();
        drain();
`endif

        // Random traffic with random backpressure.
        p0 = npop;
        k = 0; n = 0;
        while (k < 60 && n < 1000) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_op     = 3'($urandom_range(0, 7));
            out_ready = 1'($urandom_range(0, 2) != 0);
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            n++;
        end
        chk("rand_all_issued", k, 60);
        drain();
        chk("rand_result_count", npop - p0, 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic16_pipe.md
Name: logic16_pipe

Overview:
- Parametrised, pipelined successor to the combinational 16-bit inverter: bitwise logic unit over WIDTH-bit operands a, b, with an opcode-selected function (NOT, AND, OR, XOR and complements).
- Result emerges after LATENCY clock edges. Valid/ready handshake on both sides, global stall on backpressure.
- Sits between register file read and ALU writeback in the CPU datapath; also usable standalone as a registered Not16/And16/Or16 replacement.

Parameters:
- WIDTH, 16, operand/result width in bits (>=1).
- LATENCY, 2, number of pipeline register stages, legal 1..4; other values are a compile-time error (generate-time $error).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/op presented this cycle.
- in_ready  output  1  unit accepts operands this cycle.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b (ignored by NOT a / PASS a).
- in_op  input  3  function select.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out  output  WIDTH  result.

Behaviour:
- Reset values:
  - Synchronous active-high reset; on a clk edge with reset=1, all stage valid bits clear and all data registers go to 0.
  - After reset: out_valid=0, out=0, in_ready=1.
  - Reset mid-operation discards all in-flight results. No handshake completes on the reset edge.
- Opcodes:
  - 000 ~a, 001 a&b, 010 a|b, 011 a^b, 100 ~(a&b), 101 ~(a|b), 110 ~(a^b), 111 a.
  - All operations are bitwise; no carries, no width change.
- Function computed combinationally from in_a/in_b/in_op and captured into stage 1. Stages 2..LATENCY are pure delay registers (valid + data).
- Advance and stall:
  - advance = !out_valid | out_ready.
  - in_ready = advance (combinational from out_valid/out_ready; no combinational path from in_valid).
  - On a clk edge with advance=1, every stage shifts: stage1 <= {in_valid, f(in_a,in_b,in_op)}, stage k <= stage k-1.
  - advance=0 freezes every stage, including data.
- Acceptance: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Bubbles are not collapsed. A stall with empty middle stages still stalls the input.
- Data in a stage whose valid bit is 0 is don't-care except after reset (0).
- Latency and throughput:
  - Accepted at edge N, with no stalls, the result is visible with out_valid=1 after edge N+LATENCY-1, i.e. LATENCY cycles after presentation.
  - Throughput is 1 result/cycle with out_ready held 1.
- Ordering: results leave in strict acceptance order; none lost or duplicated under any out_ready pattern.
- Stable output: out and out_valid stay stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro LOGIC16_PIPE_FLAGS_EN.
- When defined, two extra outputs are added:
  - out_zr (1): result == 0.
  - out_ng (1): result[WIDTH-1].
- Both flags are computed in stage 1 and pipelined alongside the data. They obey the same valid/stall/reset rules; reset value is 0.
- When undefined, the ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then idle with WIDTH=16, LATENCY=2 -> out_valid=0, out=0x0000, in_ready=1.
- Single NOT: in_a=0x00FF, op=000, in_valid pulsed for 1 cycle, out_ready=1 -> out=0xFF00 with out_valid=1 exactly 2 cycles after presentation, for 1 cycle.
- Streaming, all 8 ops back-to-back with a=0x0F0F, b=0x3333 -> outputs 0xF0F0, 0x0303, 0x3F3F, 0x3C3C, 0xFCFC, 0xC0C0, 0xC3C3, 0x0F0F on consecutive cycles.
- Backpressure: stream 10 patterns (0x0000, 0xFFFF, 0x00FF, ... 0xAAAA with NOT) while out_ready toggles pseudo-randomly. Required:
  - in_ready=0 whenever out_valid=1 & out_ready=0.
  - Output held stable while stalled.
  - Exactly 10 inverted results, in order.
- Reset mid-stream: assert reset while 2 results are in flight and out_ready=0 -> next cycle out_valid=0, out=0, and no stale result ever appears.
- With LOGIC16_PIPE_FLAGS_EN, LATENCY=1 -> a=0xFFFF, op=000 gives out=0x0000, out_zr=1, out_ng=0. A second input a=0x0001, op=000 gives out=0xFFFE, out_zr=0, out_ng=1.
